pipe_stage_skid: RTL

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.

---
 rtl/pipe_stage_skid_pkg.sv | 13 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_stage_skid.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: shared encodings for the pipeline stage registers.
//   occ_e          occupancy encoding EMPTY/ONE/FULL (2'd0/1/2)
//   NOP_WORD       all-zero instruction word used as the default bubble
//   DEFAULT_WIDTH  default payload width of a stage register
package pipe_stage_skid_pkg;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;
    localparam logic [31:0] NOP_WORD      = 32'h0;
    localparam int          DEFAULT_WIDTH = 96;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk  in  1  rising-edge clock
//   clr  in  1  synchronous clear, wins over en
//   en   in  1  count enable
//   q    out W  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en && !(&q))
            q <= q + 1'b1;
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer, flush and stall counter.
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-high
//   flush         in   1      discard held entries, insert a bubble
//   in_valid      in   1      upstream payload valid
//   in_ready      out  1      stage can accept (occupancy != 2), from state only
//   in_data       in   WIDTH  upstream payload
//   out_valid     out  1      main register holds a valid entry
//   out_ready     in   1      downstream accepts
//   out_data      out  WIDTH  main register; BUBBLE when out_valid is low
//   occupancy     out  2      entries held (0..2)
//   stall_cycles  out  CNT_W  saturating count of out_valid & !out_ready cycles
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int               WIDTH  = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);
    occ_e             state, state_n;
    logic [WIDTH-1:0] main_q, main_n, skid_q, skid_n;
    logic             in_fire, out_fire;

    // Handshake outputs depend only on registered state, so there is no
    // combinational path from in_* to out_* or from out_ready to in_ready.
    assign in_ready  = state != OCC_FULL;
    assign out_valid = state != OCC_EMPTY;
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= OCC_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = OCC_EMPTY;
            main_n  = BUBBLE;
            skid_n  = BUBBLE;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_n  = in_data;
                        state_n = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire)
                        main_n = in_data;
                    else if (in_fire) begin
                        skid_n  = in_data;
                        state_n = OCC_FULL;
                    end else if (out_fire) begin
                        main_n  = BUBBLE;
                        state_n = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        main_n  = skid_q;
                        skid_n  = BUBBLE;
                        state_n = OCC_ONE;
                    end
                end
                default: begin
                    state_n = OCC_EMPTY;
                    main_n  = BUBBLE;
                    skid_n  = BUBBLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall (
        .clk (clk),
        .clr (reset),
        .en  (out_valid & ~out_ready),
        .q   (stall_cycles)
    );
endmodule
